// File: rtl/tracker_axis_sequencer_if.sv
// Direction requests in from the comparators and step/direction levels out to the two motors.
// The master side is the sequencer; the slave side is the comparator/motor-driver side.
interface tracker_axis_sequencer_if;
  logic [1:0] dir_teta;
  logic [1:0] dir_fi;
  logic       step_teta;
  logic       dir_out_teta;
  logic       step_fi;
  logic       dir_out_fi;

  modport master (
    input  dir_teta,
    input  dir_fi,
    output step_teta,
    output dir_out_teta,
    output step_fi,
    output dir_out_fi
  );

  modport slave (
    output dir_teta,
    output dir_fi,
    input  step_teta,
    input  dir_out_teta,
    input  step_fi,
    input  dir_out_fi
  );
endinterface

// File: rtl/tracker_axis_sequencer.sv
// Two-axis tracker sequencer: drives teta to rest, then fi, converting comparator requests
// into timed step pulses, with settle filtering, auto-mode interval, step timeout and fault.
module tracker_axis_sequencer #(
  parameter int unsigned STEP_DIV   = 50000,
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned MAX_STEPS  = 4096,
  parameter int unsigned INTERVAL   = 500000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s,
  input  logic                            start,
  input  logic                            clr_fault,
  tracker_axis_sequencer_if.master        axis,
  output logic                            busy,
  output logic                            done,
  output logic                            fault,
  output logic [2:0]                      state
);

  localparam int unsigned DivW = $clog2(STEP_DIV) + 1;
  localparam int unsigned SetW = $clog2(SETTLE_CYC) + 1;
  localparam int unsigned StpW = $clog2(MAX_STEPS) + 1;
  localparam int unsigned IntW = $clog2(INTERVAL) + 1;

  localparam logic [DivW-1:0] DivLast = DivW'(STEP_DIV - 1);
  localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYC - 1);
  localparam logic [StpW-1:0] StpLast = StpW'(MAX_STEPS - 1);
  localparam logic [StpW-1:0] StpMax  = StpW'(MAX_STEPS);
  localparam logic [IntW-1:0] IntLast = IntW'(INTERVAL - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitInt = 3'd1,
    StMoveT   = 3'd2,
    StSettleT = 3'd3,
    StMoveF   = 3'd4,
    StSettleF = 3'd5,
    StDone    = 3'd6,
    StFault   = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic            tick_q, tick_d;
  logic [StpW-1:0] steps_q, steps_d;
  logic [SetW-1:0] settle_q, settle_d;
  logic [IntW-1:0] intv_q, intv_d;
  logic            mode_q, mode_d;
  logic            dir_t_q, dir_t_d;
  logic            dir_f_q, dir_f_d;
  logic            step_t, step_f;
  logic [1:0]      cur_req;
  logic            req_mv;
  logic            div_wrap;

  // Only 01/10 request motion; 00 and 11 both mean stop.
  always_comb begin
    cur_req  = (state_q inside {StMoveF, StSettleF}) ? axis.dir_fi : axis.dir_teta;
    req_mv   = ^cur_req;
    div_wrap = (div_q == DivLast);
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    tick_d   = 1'b0;
    steps_d  = steps_q;
    settle_d = settle_q;
    intv_d   = intv_q;
    mode_d   = mode_q;
    dir_t_d  = dir_t_q;
    dir_f_d  = dir_f_q;
    step_t   = 1'b0;
    step_f   = 1'b0;

    unique case (state_q)
      StIdle: begin
        intv_d = '0;
        if (!s) begin
          state_d = StWaitInt;
          mode_d  = 1'b0;
        end else if (start) begin
          state_d = StMoveT;
          mode_d  = 1'b1;
          div_d   = '0;
          steps_d = '0;
        end
      end
      StWaitInt: begin
        if (s) begin
          state_d = StIdle;
        end else if (intv_q >= IntLast) begin
          state_d = StMoveT;
          div_d   = '0;
          steps_d = '0;
        end else begin
          intv_d = intv_q + 1'b1;
        end
      end
      StMoveT, StMoveF: begin
        if (!req_mv) begin
          state_d  = (state_q == StMoveT) ? StSettleT : StSettleF;
          settle_d = '0;
        end else begin
          // tick_q marks the cycle after terminal count, so the first pulse lands STEP_DIV
          // cycles after entry and the pulse can be gated by the request of its own cycle.
          tick_d = div_wrap;
          div_d  = div_wrap ? '0 : div_q + 1'b1;
          if (tick_q) begin
            if (state_q == StMoveT) begin
              step_t  = 1'b1;
              dir_t_d = cur_req[1];
            end else begin
              step_f  = 1'b1;
              dir_f_d = cur_req[1];
            end
            if (steps_q != StpMax) begin
              steps_d = steps_q + 1'b1;
            end
            if (steps_q >= StpLast) begin
              state_d = StFault;
            end
          end
        end
      end
      StSettleT, StSettleF: begin
        if (req_mv) begin
          // Step count is kept so the timeout stays cumulative across bounces.
          state_d = (state_q == StSettleT) ? StMoveT : StMoveF;
          div_d   = '0;
        end else if (settle_q >= SetLast) begin
          if (state_q == StSettleT) begin
            state_d = StMoveF;
            div_d   = '0;
            steps_d = '0;
          end else begin
            state_d = StDone;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StDone: begin
        intv_d  = '0;
        state_d = mode_q ? StIdle : StWaitInt;
      end
      StFault: begin
        if (clr_fault) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      div_q    <= '0;
      tick_q   <= 1'b0;
      steps_q  <= '0;
      settle_q <= '0;
      intv_q   <= '0;
      mode_q   <= 1'b0;
      dir_t_q  <= 1'b0;
      dir_f_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      steps_q  <= steps_d;
      settle_q <= settle_d;
      intv_q   <= intv_d;
      mode_q   <= mode_d;
      dir_t_q  <= dir_t_d;
      dir_f_q  <= dir_f_d;
    end
  end

  // Outputs decode from state_q, so an asynchronous reset cuts a pulse in the same instant.
  assign axis.step_teta    = step_t;
  assign axis.dir_out_teta = dir_t_d;
  assign axis.step_fi      = step_f;
  assign axis.dir_out_fi   = dir_f_d;
  assign busy              = state_q inside {StMoveT, StSettleT, StMoveF, StSettleF};
  assign done              = (state_q == StDone);
  assign fault             = (state_q == StFault);
  assign state             = state_q;

endmodule
